imm_sequencer: RTL and testbench

IMM_SEQUENCER -- requirements
Module: imm_sequencer

---
 rtl/cpu_seq_pkg.sv | 52 +++++
 rtl/imm_sequencer_bus_timeout.sv | 30 +++
 rtl/imm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_imm_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the immediate-instruction sequencer: states, opcodes,
// PC source selects, bus timeout limit and the opcode classifier.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_REG,
        CLS_ALU_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_NOP,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hA;
    localparam logic [3:0] OP_JUMP   = 4'hB;
    localparam logic [3:0] OP_NOP    = 4'hF;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam int TIMEOUT_LIMIT = 16;

    function automatic op_class_e decode_op(input logic [3:0] op);
        op_class_e cls;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: cls = CLS_ALU_REG;
            4'h4, 4'h5, 4'h6, 4'h7: cls = CLS_ALU_IMM;
            OP_LOAD:                cls = CLS_LOAD;
            OP_STORE:               cls = CLS_STORE;
            OP_BRANCH:              cls = CLS_BRANCH;
            OP_JUMP:                cls = CLS_JUMP;
            OP_NOP:                 cls = CLS_NOP;
            default:                cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_sequencer_bus_timeout.sv
// Bus watchdog: counts consecutive request cycles without ack and flags the
// cycle that would be the LIMIT-th unanswered one.
module bus_timeout
    import cpu_seq_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    // An ack on the last allowed cycle wins over expiry.
    always_comb begin
        cnt_d   = (req && !ack) ? cnt_q + 1'b1 : '0;
        expired = req && !ack && (cnt_q == CW'(LIMIT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/imm_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with bus timeout.
// Optional retire counter enabled by defining IMM_SEQ_RETIRE_CNT_EN.
module imm_sequencer
    import cpu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic [7:0]  imm,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halt,
    output logic        bus_err,
    output logic [2:0]  state
`ifdef IMM_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] imm_q, imm_d;
    logic       run_q, run_d;
    logic       bus_err_q, bus_err_d;
    logic       bus_req, bus_ack, tmo_expired;
    logic       unused_reg_fields;
    op_class_e  cls;

    // Register specifiers live in imem_rdata[11:8] and are consumed by the datapath.
    assign unused_reg_fields = ^imem_rdata[11:8];

    assign cls     = decode_op(op_q);
    assign imm     = imm_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

    // run_q holds off the first fetch until one edge after reset release.
    assign bus_req = (state_q == ST_FETCH && run_q) || (state_q == ST_MEM);
    assign bus_ack = (state_q == ST_FETCH && run_q && imem_ack) ||
                     (state_q == ST_MEM && dmem_ack);

    bus_timeout #(.LIMIT(TIMEOUT_LIMIT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus_req),
        .ack     (bus_ack),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        run_d       = 1'b1;
        bus_err_d   = bus_err_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        pc_src      = PC_SRC_SEQ;
        alu_src_imm = 1'b0;
        alu_op      = 2'b00;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        halt        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = run_q;
                if (run_q && imem_ack) begin
                    ir_en   = 1'b1;
                    op_d    = imem_rdata[15:12];
                    imm_d   = imem_rdata[7:0];
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                state_d = (cls == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_op      = op_q[1:0];
                alu_src_imm = (cls == CLS_ALU_IMM) || (cls == CLS_LOAD) || (cls == CLS_STORE);
                case (cls)
                    CLS_ALU_REG, CLS_ALU_IMM: state_d = ST_WB;
                    CLS_LOAD, CLS_STORE:      state_d = ST_MEM;
                    CLS_BRANCH: begin
                        pc_en   = 1'b1;
                        pc_src  = alu_zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
                        state_d = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_en   = 1'b1;
                        pc_src  = PC_SRC_JUMP;
                        state_d = ST_FETCH;
                    end
                    CLS_NOP: begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CLS_STORE);
                if (dmem_ack) begin
                    if (cls == CLS_STORE) begin
                        pc_en   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (cls == CLS_LOAD);
                pc_en   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            imm_q     <= '0;
            run_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            run_q     <= run_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef IMM_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb retired_d = pc_en ? retired_q + 16'd1 : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_imm_sequencer.sv
// Self-checking bench for imm_sequencer: per-cycle trace model built from the
// instruction-level rules, a latency table, corner sequences and random runs.
module tb_imm_sequencer;
    import cpu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        alu_zero;
    logic        ir_en, pc_en;
    logic [1:0]  pc_src;
    logic [7:0]  imm;
    logic        alu_src_imm;
    logic [1:0]  alu_op;
    logic        reg_we, wb_sel, halt, bus_err;
    logic [2:0]  state;
`ifdef IMM_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    imm_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .alu_zero    (alu_zero),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .imm         (imm),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .halt        (halt),
        .bus_err     (bus_err),
        .state       (state)
`ifdef IMM_SEQ_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_en, dmem_req, dmem_we, pc_en;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       alu_src_imm, reg_we, wb_sel, halt, bus_err;
        logic [7:0] imm;
    } obs_t;

    typedef struct {
        obs_t        exp;
        logic        iack, dack, zero;
        logic [15:0] rdata;
        logic [15:0] ret;
    } step_t;

    typedef struct {
        logic [15:0] instr;
        int          iw;
        int          dw;
        logic        zero;
        int          lat;
        logic        halt;
        logic        berr;
    } vec_t;

    localparam int TMO = 16;
    localparam int K_ALUR = 0, K_ALUI = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JMP = 5, K_NOP = 6, K_ILL = 7;

    step_t       plan[$];
    logic [7:0]  m_imm;
    logic [15:0] m_ret;
    logic [15:0] m_instr;
    int          nvec  = 0;
    int          nfail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    function automatic int kind(input logic [3:0] op);
        if (op <= 4'h3) return K_ALUR;
        if (op <= 4'h7) return K_ALUI;
        case (op)
            4'h8:    return K_LD;
            4'h9:    return K_ST;
            4'hA:    return K_BR;
            4'hB:    return K_JMP;
            4'hF:    return K_NOP;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int pick();
        int r = $urandom_range(0, 19);
        if (r == 0) return 16;
        if (r == 1) return 15;
        return r % 4;
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o = '0;
        o.st  = st;
        o.imm = m_imm;
        return o;
    endfunction

    function automatic void add(input obs_t o, input logic iack, input logic dack, input logic zero);
        step_t s;
        s.exp   = o;
        s.iack  = iack;
        s.dack  = dack;
        s.zero  = zero;
        s.rdata = o.imem_req ? m_instr : 16'($urandom);
        s.ret   = m_ret;
        if (o.pc_en) m_ret++;
        plan.push_back(s);
    endfunction

    function automatic void add_halt(input logic berr);
        obs_t o;
        for (int k = 0; k < 3; k++) begin
            o = mk(ST_HALT);
            o.halt    = 1'b1;
            o.bus_err = berr;
            add(o, rb(), rb(), rb());
        end
    endfunction

    // Appends the expected cycle trace of one instruction; returns 1 if it halts.
    function automatic bit build(input logic [15:0] instr, input int iw, input int dw, input logic zero);
        obs_t o;
        int   k = kind(instr[15:12]);
        m_instr = instr;
        for (int w = 0; w <= iw && w < TMO; w++) begin
            o = mk(ST_FETCH);
            o.imem_req = 1'b1;
            o.ir_en    = (w == iw);
            add(o, (w == iw), rb(), rb());
        end
        if (iw >= TMO) begin
            add_halt(1'b1);
            return 1'b1;
        end
        m_imm = instr[7:0];
        add(mk(ST_DECODE), rb(), rb(), rb());
        if (k == K_ILL) begin
            add_halt(1'b0);
            return 1'b1;
        end
        o = mk(ST_EXEC);
        o.alu_op      = instr[13:12];
        o.alu_src_imm = (k == K_ALUI || k == K_LD || k == K_ST);
        if (k == K_BR)  begin o.pc_en = 1'b1; o.pc_src = zero ? 2'b01 : 2'b00; end
        if (k == K_JMP) begin o.pc_en = 1'b1; o.pc_src = 2'b10; end
        if (k == K_NOP) o.pc_en = 1'b1;
        add(o, rb(), rb(), (k == K_BR) ? zero : rb());
        if (k == K_BR || k == K_JMP || k == K_NOP) return 1'b0;
        if (k == K_LD || k == K_ST) begin
            for (int w = 0; w <= dw && w < TMO; w++) begin
                o = mk(ST_MEM);
                o.dmem_req = 1'b1;
                o.dmem_we  = (k == K_ST);
                o.pc_en    = (w == dw && k == K_ST);
                add(o, rb(), (w == dw), rb());
            end
            if (dw >= TMO) begin
                add_halt(1'b1);
                return 1'b1;
            end
            if (k == K_ST) return 1'b0;
        end
        o = mk(ST_WB);
        o.reg_we = 1'b1;
        o.wb_sel = (k == K_LD);
        o.pc_en  = 1'b1;
        add(o, rb(), rb(), rb());
        return 1'b0;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st          = state;
        o.imem_req    = imem_req;
        o.ir_en       = ir_en;
        o.dmem_req    = dmem_req;
        o.dmem_we     = dmem_we;
        o.pc_en       = pc_en;
        o.pc_src      = pc_src;
        o.alu_op      = alu_op;
        o.alu_src_imm = alu_src_imm;
        o.reg_we      = reg_we;
        o.wb_sel      = wb_sel;
        o.halt        = halt;
        o.bus_err     = bus_err;
        o.imm         = imm;
        return o;
    endfunction

    // Called at posedge+1; leaves the DUT one edge past reset release, fetching.
    task automatic do_reset();
        obs_t z;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        alu_zero   = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        z    = '0;
        z.st = ST_FETCH;
        chk("reset outputs", 64'(sample()), 64'(z));
`ifdef IMM_SEQ_RETIRE_CNT_EN
        chk("reset retired", 64'(retired), 64'(0));
`endif
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hC000;
        @(negedge clk);
        chk("no imem_req before first edge", 64'(imem_req), 64'(0));
        @(posedge clk);
        #1;
        m_imm = '0;
        m_ret = '0;
        plan.delete();
    endtask

    task automatic apply(input int nmax, output int lat);
        obs_t act;
        lat = 0;
        for (int i = 0; i < plan.size() && i < nmax; i++) begin
            imem_ack   = plan[i].iack;
            dmem_ack   = plan[i].dack;
            alu_zero   = plan[i].zero;
            imem_rdata = plan[i].rdata;
            @(negedge clk);
            act = sample();
            chk($sformatf("trace[%0d] exp_state %0d", i, plan[i].exp.st), 64'(act), 64'(plan[i].exp));
`ifdef IMM_SEQ_RETIRE_CNT_EN
            chk($sformatf("retired[%0d]", i), 64'(retired), 64'(plan[i].ret));
`endif
            if (lat == 0 && (act.pc_en || act.halt)) lat = i + 1;
            @(posedge clk);
            #1;
        end
        plan.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[14];
        int          lat;
        bit          halted;
        logic [15:0] ins;

        // {instr, imem wait, dmem wait, alu_zero, cycles to retire/halt, halt, bus_err}
        vt[0]  = '{16'h4A94, 0,  0,  1'b0, 4,  1'b0, 1'b0};
        vt[1]  = '{16'h800B, 0,  3,  1'b0, 8,  1'b0, 1'b0};
        vt[2]  = '{16'hA072, 0,  0,  1'b1, 3,  1'b0, 1'b0};
        vt[3]  = '{16'hA072, 0,  0,  1'b0, 3,  1'b0, 1'b0};
        vt[4]  = '{16'h9123, 0,  0,  1'b0, 4,  1'b0, 1'b0};
        vt[5]  = '{16'hB0FF, 0,  0,  1'b0, 3,  1'b0, 1'b0};
        vt[6]  = '{16'hF000, 0,  0,  1'b0, 3,  1'b0, 1'b0};
        vt[7]  = '{16'h1234, 2,  0,  1'b0, 6,  1'b0, 1'b0};
        vt[8]  = '{16'hC000, 0,  0,  1'b0, 3,  1'b1, 1'b0};
        vt[9]  = '{16'h4A94, 16, 0,  1'b0, 17, 1'b1, 1'b1};
        vt[10] = '{16'h4A94, 15, 0,  1'b0, 19, 1'b0, 1'b0};
        vt[11] = '{16'h800B, 0,  16, 1'b0, 20, 1'b1, 1'b1};
        vt[12] = '{16'h800B, 0,  15, 1'b0, 20, 1'b0, 1'b0};
        vt[13] = '{16'hE000, 0,  0,  1'b0, 3,  1'b1, 1'b0};

        for (int v = 0; v < 14; v++) begin
            do_reset();
            void'(build(vt[v].instr, vt[v].iw, vt[v].dw, vt[v].zero));
            apply(1000, lat);
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'(vt[v].lat));
            chk($sformatf("vec%0d halt,bus_err", v), 64'({halt, bus_err}), 64'({vt[v].halt, vt[v].berr}));
        end

        // Back-to-back branches, taken then not taken.
        do_reset();
        void'(build(16'hA072, 0, 0, 1'b1));
        void'(build(16'hA072, 0, 0, 1'b0));
        apply(1000, lat);

        // Reset in the middle of a load's MEM wait, then a late dmem_ack.
        do_reset();
        void'(build(16'hF000, 0, 0, 1'b0));
        void'(build(16'h800B, 0, 10, 1'b0));
        apply(8, lat);
        rst_n = 1'b0;
        #1;
        chk("mid-MEM reset dmem_req", 64'(dmem_req), 64'(0));
        chk("mid-MEM reset state", 64'(state), 64'(ST_FETCH));
`ifdef IMM_SEQ_RETIRE_CNT_EN
        chk("mid-MEM reset retired", 64'(retired), 64'(0));
`endif
        dmem_ack = 1'b1;
        imem_ack = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset idle reqs", 64'({imem_req, dmem_req}), 64'(2'b00));
        @(posedge clk);
        #1;
        chk("late dmem_ack ignored", 64'({state, imem_req, dmem_req}), 64'({3'(ST_FETCH), 2'b10}));
        m_imm = '0;
        m_ret = '0;
        void'(build(16'h4A94, 0, 0, 1'b0));
        apply(1000, lat);

        // Random instruction streams until halt or stream end.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int n = 0; n < 25; n++) begin
                ins    = {4'($urandom_range(0, 15)), 12'($urandom)};
                halted = build(ins, pick(), pick(), rb());
                apply(1000, lat);
                if (halted) break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
